// File: rtl/tile_result_drain.sv
// Drains a single-PE tile's south-side result bundle into a small FIFO,
// tagging each beat with its row within the output block.
module tile_result_drain #(
    parameter int C_W   = 19,
    parameter int B_W   = 19,
    parameter int DEPTH = 4,
    parameter int ROWS  = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int RW   = $clog2(ROWS)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [C_W-1:0] io_in_c,
    input  logic [B_W-1:0] io_in_b,
    input  logic           io_in_control_propagate,
    input  logic           io_in_valid,
    input  logic           io_deq_ready,
    output logic           io_deq_valid,
    output logic [C_W-1:0] io_deq_bits_c,
    output logic [B_W-1:0] io_deq_bits_b,
    output logic           io_deq_bits_propagate,
    output logic [RW-1:0]  io_deq_bits_row,
    output logic           io_deq_bits_last,
    output logic [AW:0]    io_count,
    output logic           io_overflow,
    input  logic           io_clear_overflow
);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [C_W-1:0] mem_c   [DEPTH];
    logic [B_W-1:0] mem_b   [DEPTH];
    logic           mem_p   [DEPTH];
    logic [RW-1:0]  mem_row [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [RW-1:0] row_cnt, beat_row;
    logic          last_prop, overflow;
    logic          deq_fire, enq;

    // A propagate toggle marks the start of a new output block.
    assign beat_row = (io_in_control_propagate != last_prop) ? '0 : row_cnt;
    assign io_deq_valid = (count != '0);
    assign deq_fire = io_deq_valid && io_deq_ready;
    assign enq = io_in_valid && ((count != FULL) || deq_fire);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            row_cnt   <= '0;
            last_prop <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // Row tracking advances on dropped beats too, keeping block alignment.
            if (io_in_valid) begin
                row_cnt   <= beat_row + 1'b1;
                last_prop <= io_in_control_propagate;
            end
            if (enq)      wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (io_in_valid && !enq)    overflow <= 1'b1;
            else if (io_clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem_c[wr_ptr]   <= io_in_c;
            mem_b[wr_ptr]   <= io_in_b;
            mem_p[wr_ptr]   <= io_in_control_propagate;
            mem_row[wr_ptr] <= beat_row;
        end
    end

    // Head is masked to zero while empty so stale storage never leaks out.
    assign io_deq_bits_c         = io_deq_valid ? mem_c[rd_ptr]   : '0;
    assign io_deq_bits_b         = io_deq_valid ? mem_b[rd_ptr]   : '0;
    assign io_deq_bits_propagate = io_deq_valid ? mem_p[rd_ptr]   : 1'b0;
    assign io_deq_bits_row       = io_deq_valid ? mem_row[rd_ptr] : '0;
    assign io_deq_bits_last      = io_deq_valid && (mem_row[rd_ptr] == LAST_ROW);
    assign io_count              = count;
    assign io_overflow           = overflow;
endmodule

// File: tb/tb_tile_result_drain.sv
// Directed bench for tile_result_drain with hand-computed expectations.
module tb_tile_result_drain;
    logic        clock = 1'b0;
    logic        reset;
    logic [18:0] io_in_c, io_in_b;
    logic        io_in_control_propagate, io_in_valid, io_deq_ready;
    logic        io_deq_valid;
    logic [18:0] io_deq_bits_c, io_deq_bits_b;
    logic        io_deq_bits_propagate;
    logic [2:0]  io_deq_bits_row;
    logic        io_deq_bits_last;
    logic [2:0]  io_count;
    logic        io_overflow, io_clear_overflow;

    int n_run = 0, n_fail = 0;

    tile_result_drain #(.C_W(19), .B_W(19), .DEPTH(4), .ROWS(8)) dut (
        .clock(clock), .reset(reset),
        .io_in_c(io_in_c), .io_in_b(io_in_b),
        .io_in_control_propagate(io_in_control_propagate), .io_in_valid(io_in_valid),
        .io_deq_ready(io_deq_ready), .io_deq_valid(io_deq_valid),
        .io_deq_bits_c(io_deq_bits_c), .io_deq_bits_b(io_deq_bits_b),
        .io_deq_bits_propagate(io_deq_bits_propagate), .io_deq_bits_row(io_deq_bits_row),
        .io_deq_bits_last(io_deq_bits_last), .io_count(io_count),
        .io_overflow(io_overflow), .io_clear_overflow(io_clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [18:0] c, input logic [18:0] b, input logic p);
        io_in_valid = v;
        io_in_c = c;
        io_in_b = b;
        io_in_control_propagate = p;
    endtask

    task automatic head(input string tag, input logic [18:0] c, input logic [2:0] row, input logic last);
        chk({tag, ".valid"}, 64'(io_deq_valid), 64'd1);
        chk({tag, ".c"}, 64'(io_deq_bits_c), 64'(c));
        chk({tag, ".row"}, 64'(io_deq_bits_row), 64'(row));
        chk({tag, ".last"}, 64'(io_deq_bits_last), 64'(last));
    endtask

    logic [18:0] exp_c[4];
    logic [2:0]  exp_row[4];
    logic        exp_p[4];

    initial begin
        reset = 1'b1;
        io_deq_ready = 1'b1;
        io_clear_overflow = 1'b0;
        drive(0, 0, 0, 0);
        step();
        chk("rst.valid", 64'(io_deq_valid), 0);
        chk("rst.count", 64'(io_count), 0);
        chk("rst.ovf", 64'(io_overflow), 0);
        chk("rst.c", 64'(io_deq_bits_c), 0);
        chk("rst.row", 64'(io_deq_bits_row), 0);
        reset = 1'b0;
        step();

        // Streaming at ready=1: one-cycle latency, rows 0..7, last only on row 7
        for (int i = 0; i < 8; i++) begin
            drive(1, 19'(i + 1), 19'(100 + i), 0);
            step();
            head("stream", 19'(i + 1), 3'(i), i == 7);
            chk("stream.b", 64'(io_deq_bits_b), 64'(100 + i));
            chk("stream.count", 64'(io_count), 1);
            chk("stream.ovf", 64'(io_overflow), 0);
        end
        drive(0, 0, 0, 0);
        step();
        chk("stream.empty", 64'(io_deq_valid), 0);
        chk("stream.empty_c", 64'(io_deq_bits_c), 0);

        // Overflow: 6 beats with ready=0, last two dropped
        io_deq_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 19'(10 + i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        chk("ovf.count", 64'(io_count), 4);
        chk("ovf.flag", 64'(io_overflow), 1);
        io_deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            head("ovf.drain", 19'(10 + k), 3'(k), 0);
            step();
        end
        chk("ovf.drained", 64'(io_count), 0);

        // Clear alone: 1 -> 0
        io_clear_overflow = 1'b1;
        step();
        io_clear_overflow = 1'b0;
        chk("clr.alone", 64'(io_overflow), 0);

        // Full plus simultaneous enq/deq; row counter is at 6 here
        io_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 19'(30 + i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        chk("full.count", 64'(io_count), 4);
        head("full.head", 30, 6, 0);
        io_deq_ready = 1'b1;
        drive(1, 20, 0, 0);
        step();
        drive(0, 0, 0, 0);
        chk("simul.count", 64'(io_count), 4);
        chk("simul.ovf", 64'(io_overflow), 0);
        exp_c = '{31, 32, 33, 20};
        exp_row = '{7, 0, 1, 2};
        for (int k = 0; k < 4; k++) begin
            head("simul.drain", exp_c[k], exp_row[k], k == 0);
            step();
        end
        chk("simul.drained", 64'(io_count), 0);

        // Propagate toggle restarts rows; sign bits carried bit-exact
        reset = 1'b1;
        #2;
        reset = 1'b0;
        io_deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 19'(i + 1), 0, 0);
            step();
        end
        drive(1, 19'h7FFFF, 19'h40000, 1);
        step();
        drive(0, 0, 0, 0);
        io_deq_ready = 1'b1;
        exp_c = '{1, 2, 3, 19'h7FFFF};
        exp_row = '{0, 1, 2, 0};
        exp_p = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            head("prop", exp_c[k], exp_row[k], 0);
            chk("prop.p", 64'(io_deq_bits_propagate), 64'(exp_p[k]));
            if (k == 3) chk("prop.b", 64'(io_deq_bits_b), 64'h40000);
            step();
        end

        // Clear coinciding with a drop: set wins
        io_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 19'(40 + i), 0, 1);
            step();
        end
        chk("clrdrop.pre", 64'(io_overflow), 0);
        drive(1, 44, 0, 1);
        io_clear_overflow = 1'b1;
        step();
        io_clear_overflow = 1'b0;
        drive(0, 0, 0, 0);
        chk("clrdrop.ovf", 64'(io_overflow), 1);
        chk("clrdrop.count", 64'(io_count), 4);

        // Async reset between edges with count = 3
        io_deq_ready = 1'b1;
        step();
        io_deq_ready = 1'b0;
        chk("arst.pre", 64'(io_count), 3);
        #3;
        reset = 1'b1;
        #1;
        chk("arst.valid", 64'(io_deq_valid), 0);
        chk("arst.count", 64'(io_count), 0);
        chk("arst.ovf", 64'(io_overflow), 0);
        chk("arst.c", 64'(io_deq_bits_c), 0);
        #1;
        reset = 1'b0;
        drive(1, 50, 0, 0);
        step();
        drive(0, 0, 0, 0);
        head("arst.after", 50, 0, 0);
        chk("arst.count1", 64'(io_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
